drum_mul_arbiter: RTL and testbench
===================================

Name: drum_mul_arbiter

Overview:
- Shares one DRUMk_M_N_s approximate multiplier instance among NREQ independent requesters.
- Each requester uses a valid/ready handshake; the arbiter grants one request per cycle, round-robin.
- Operands pass through a 2-stage registered pipeline (operand register, multiplier, result register).
- Each result carries the ID of the requester that issued it, so downstream logic can route it back.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- K, 6: DRUM truncation width, passed to the multiplier.
- N, 16: operand A width.
- M, 16: operand B width.
- IDW, $clog2(NREQ): requester-ID width, derived, not overridable.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*N  packed operand A; requester i at [i*N +: N]
- req_b  in  NREQ*M  packed operand B; requester i at [i*M +: M]
- req_exact  in  NREQ  exact-product request; used only with the optional feature
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts result
- res_data  out  N+M  product
- res_id  out  IDW  requester index of the result
- busy  out  1  high when either pipeline stage is occupied

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - s1_vld=0, s2_vld=0, rr_ptr=0.
  - res_valid=0, res_data=0, res_id=0, busy=0.
  - req_ready is combinational and evaluates to 0 during reset.
- Arbitration (combinational):
  - Search starts at rr_ptr, then rr_ptr+1, ... modulo NREQ.
  - The first i with req_valid[i]=1 is the candidate.
  - req_ready[i]=1 only for the candidate, and only when s1_adv=1.
  - req_ready never depends on a requester's own req_ready; req_ready may depend on req_valid.
- Pipeline advance:
  - s2_adv = !s2_vld | res_ready.
  - s1_adv = !s1_vld | s2_adv.
- Accept: when req_valid[i] & req_ready[i], at the clock edge:
  - s1 captures a, b, id=i (plus the exact bit with the feature); s1_vld=1.
  - rr_ptr <= (i+1) mod NREQ.
  - rr_ptr holds whenever nothing is accepted.
- s1 with s1_adv=1 and no new accept: s1_vld <= 0.
- Stage 2:
  - When s2_adv=1: s2_vld <= s1_vld.
  - If s1_vld: res_data <= multiplier output computed from s1 operands; res_id <= s1 id.
  - When s2_adv=0: the result register holds. res_data and res_id stay stable while res_valid=1 and res_ready=0.
- Latency and throughput:
  - Accept at edge E; res_valid=1 after edge E+1 (visible in cycle E+1).
  - Throughput is 1 result per cycle with res_ready tied high.
  - Full backpressure: with res_ready=0 and both stages full, req_ready=0 for all requesters. No result is dropped or duplicated.
- Simultaneous events:
  - s2 drains and s1 refills in the same cycle; this is allowed and gives no bubble.
  - All requesters valid: grant order i, i+1, ... with no starvation. Maximum wait is NREQ-1 grants.
- A requester may drop req_valid without being accepted; nothing is captured.
- Multiplier arithmetic:
  - Unsigned DRUM with parameter K.
  - Operands below 2^K produce an exact product.
  - Result width is N+M; no overflow is possible.
- busy = s1_vld | s2_vld.
- Reset mid-operation: in-flight products are discarded, res_valid drops immediately, and rr_ptr returns to 0.

Optional Feature:
- Macro DRUM_ARB_EXACT_BYPASS_EN.
- Defined:
  - s1 also stores req_exact[i].
  - Stage 2 loads the full exact product a*b instead of the DRUM result when the stored bit is 1.
  - Latency and handshake are unchanged.
- Undefined:
  - req_exact is ignored and no exact multiplier is synthesised.
  - All results come from the DRUM instance.

Test Plan:
- Reset: assert rst_n=0 mid-stream with s1 and s2 full -> res_valid=0, busy=0 immediately. After release, req0 a=5 b=7 -> res_data=35, res_id=0, valid after 2 edges.
- Approximation: req2 a=255 b=3, K=6 -> res_data=756 (exact product 765), res_id=2. With DRUM_ARB_EXACT_BYPASS_EN and req_exact[2]=1 -> res_data=765.
- Round-robin: all 4 requesters valid continuously with distinct operands, res_ready=1 -> res_id sequence 0,1,2,3,0,... with one result per cycle. After reset, the first grant goes to 0.
- Backpressure: stream from req1, hold res_ready=0 for 5 cycles -> exactly 2 requests accepted. res_data is stable, req_ready=0. On release, results arrive in order with no loss.
- Pointer fairness: only req3 valid, accepted -> rr_ptr=0. Then req0 and req3 both valid -> req0 granted first, then req3.
- Drain/refill: res_ready toggles 1,0,1,0 while req0 is valid -> each result is seen exactly once, and the accept count equals the result count.

Source files
------------

// File: rtl/drum_mul_arbiter.sv
// Round-robin arbiter sharing one DRUM approximate multiplier among NREQ valid/ready requesters.
// Optional macro DRUM_ARB_EXACT_BYPASS_EN: a request with req_exact set receives the exact product.

module drum_mul #(
    parameter int K = 6,
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic [N-1:0]   a,
    input  logic [M-1:0]   b,
    output logic [N+M-1:0] p
);
    localparam int LAW = (N > 1) ? $clog2(N) : 1;
    localparam int LBW = (M > 1) ? $clog2(M) : 1;

    logic [LAW-1:0] lead_a;
    logic [LAW-1:0] sh_a;
    logic [LBW-1:0] lead_b;
    logic [LBW-1:0] sh_b;
    logic [N-1:0]   a_shr;
    logic [M-1:0]   b_shr;
    logic [K-1:0]   ta;
    logic [K-1:0]   tb;
    logic [N+M-1:0] core;

    // Keep K bits from the leading one down; forcing the kept LSB high unbiases the truncation.
    always_comb begin
        lead_a = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) lead_a = LAW'(i);
        end
        lead_b = '0;
        for (int i = 0; i < M; i++) begin
            if (b[i]) lead_b = LBW'(i);
        end
        sh_a  = ((a >> K) != '0) ? lead_a - LAW'(K - 1) : '0;
        sh_b  = ((b >> K) != '0) ? lead_b - LBW'(K - 1) : '0;
        a_shr = a >> sh_a;
        b_shr = b >> sh_b;
        ta    = a_shr[K-1:0];
        tb    = b_shr[K-1:0];
        if (sh_a != '0) ta[0] = 1'b1;
        if (sh_b != '0) tb[0] = 1'b1;
        core  = (N+M)'(ta) * (N+M)'(tb);
        p     = (core << sh_a) << sh_b;
    end
endmodule

module drum_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int K    = 6,
    parameter int N    = 16,
    parameter int M    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*N-1:0]        req_a,
    input  logic [NREQ*M-1:0]        req_b,
    input  logic [NREQ-1:0]          req_exact,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [N+M-1:0]           res_data,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cand_id;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] s1_id;
    logic           cand_found;
    logic           s1_vld;
    logic           s2_vld;
    logic           s1_adv;
    logic           s2_adv;
    logic           accept;
    logic [N-1:0]   s1_a;
    logic [M-1:0]   s1_b;
    logic [N-1:0]   sel_a;
    logic [M-1:0]   sel_b;
    logic [N+M-1:0] drum_p;
    logic [N+M-1:0] stage2_p;

    assign s2_adv    = !s2_vld || res_ready;
    assign s1_adv    = !s1_vld || s2_adv;
    assign res_valid = s2_vld;
    assign busy      = s1_vld || s2_vld;

    // Search from rr_ptr upward, wrapping; the first valid requester is the candidate.
    always_comb begin
        cand_found = 1'b0;
        cand_id    = '0;
        idx        = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx = IDW'((int'(rr_ptr) + off) % NREQ);
            if (!cand_found && req_valid[idx]) begin
                cand_found = 1'b1;
                cand_id    = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && cand_found && s1_adv) req_ready[cand_id] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (cand_id == IDW'(i)) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*M +: M];
            end
        end
    end

    drum_mul #(.K(K), .N(N), .M(M)) u_drum (
        .a (s1_a),
        .b (s1_b),
        .p (drum_p)
    );

`ifdef DRUM_ARB_EXACT_BYPASS_EN
    logic s1_exact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_exact <= 1'b0;
        end else if (accept) begin
            s1_exact <= req_exact[cand_id];
        end
    end

    assign stage2_p = s1_exact ? (N+M)'(s1_a) * (N+M)'(s1_b) : drum_p;
`else
    logic unused_exact;
    assign unused_exact = ^req_exact;
    assign stage2_p     = drum_p;
`endif

    // Stage 1 refills in the same cycle stage 2 drains, so a full pipe streams without bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            rr_ptr   <= '0;
            s2_vld   <= 1'b0;
            res_data <= '0;
            res_id   <= '0;
        end else begin
            if (accept) begin
                s1_vld <= 1'b1;
                s1_a   <= sel_a;
                s1_b   <= sel_b;
                s1_id  <= cand_id;
                rr_ptr <= (cand_id == IDW'(NREQ - 1)) ? '0 : cand_id + IDW'(1);
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
            if (s2_adv) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    res_data <= stage2_p;
                    res_id   <= s1_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Randomized bench for drum_mul_arbiter against a queue-based reference model of arbitration and DRUM math.
`timescale 1ns/1ps
module tb_drum_mul_arbiter;
    localparam int NREQ = 4;
    localparam int K    = 6;
    localparam int N    = 16;
    localparam int M    = 16;
    localparam int IDW  = 2;
`ifdef DRUM_ARB_EXACT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a = '0;
    logic [NREQ*M-1:0] req_b = '0;
    logic [NREQ-1:0]   req_exact = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [N+M-1:0]    res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;

    drum_mul_arbiter #(.NREQ(NREQ), .K(K), .N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_exact (req_exact),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned a;
        longint unsigned b;
        int              id;
        bit              exact;
        bit              fresh;
    } item_t;

    item_t mq[$];
    int    next_start = 0;
    int    checks = 0;
    int    errors = 0;
    int    acc_seen = 0;
    int    res_seen = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // DRUM operand reduction: small values pass through, larger ones keep K bits from the leading one.
    function automatic longint unsigned drumOperand(input longint unsigned x, output int sh);
        int lead;
        sh = 0;
        if (x < (64'd1 << K)) return x;
        lead = 0;
        while ((x >> lead) > 1) lead++;
        sh = lead - K + 1;
        return (x >> sh) | 64'd1;
    endfunction

    function automatic longint unsigned expectedProduct(input longint unsigned a, input longint unsigned b,
                                                        input bit exact);
        int sa;
        int sb;
        longint unsigned ta;
        longint unsigned tb;
        if (BYPASS && exact) return a * b;
        ta = drumOperand(a, sa);
        tb = drumOperand(b, sb);
        return (ta * tb) << (sa + sb);
    endfunction

    function automatic logic [NREQ-1:0] expectedReady();
        logic [NREQ-1:0] r;
        r = '0;
        if (!rst_n) return r;
        if (mq.size() >= 2 && !res_ready) return r;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (next_start + k) % NREQ;
            if (req_valid[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Reference model advances on each rising edge from the inputs that were presented before it.
    always @(posedge clk) begin
        logic [NREQ-1:0] er;
        bit              pop;
        item_t           it;
        if (!rst_n) begin
            mq.delete();
            next_start = 0;
        end else begin
            er  = expectedReady();
            pop = (mq.size() > 0) && !mq[0].fresh && res_ready;
            foreach (mq[j]) mq[j].fresh = 1'b0;
            if (pop) void'(mq.pop_front());
            for (int i = 0; i < NREQ; i++) begin
                if (er[i]) begin
                    it.a     = req_a[i*N +: N];
                    it.b     = req_b[i*M +: M];
                    it.id    = i;
                    it.exact = req_exact[i];
                    it.fresh = 1'b1;
                    mq.push_back(it);
                    next_start = (i + 1) % NREQ;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        checkOutput("req_ready", 64'(req_ready), 64'(expectedReady()));
        ev = (mq.size() > 0) && !mq[0].fresh;
        checkOutput("res_valid", 64'(res_valid), 64'(ev));
        checkOutput("busy", 64'(busy), 64'(mq.size() > 0));
        if (ev) begin
            checkOutput("res_data", 64'(res_data), expectedProduct(mq[0].a, mq[0].b, mq[0].exact));
            checkOutput("res_id", 64'(res_id), 64'(mq[0].id));
        end
        if (|(req_valid & req_ready)) acc_seen++;
        if (res_valid && res_ready) res_seen++;
    end

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] ex, input logic rr);
        @(posedge clk);
        #1;
        req_valid = v;
        req_exact = ex;
        res_ready = rr;
    endtask

    task automatic setOperand(input int i, input logic [N-1:0] a, input logic [M-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*M +: M] = b;
    endtask

    task automatic randomOperands();
        for (int i = 0; i < NREQ; i++) begin
            setOperand(i, N'($urandom) >> $urandom_range(0, N - 1), M'($urandom) >> $urandom_range(0, M - 1));
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mq.delete();
        next_start = 0;
        #1;
        checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
    endtask

    initial begin
        int a0;
        int r0;
        logic [N+M-1:0] held;

        checkOutput("model_5x7", expectedProduct(5, 7, 1'b0), 64'd35);
        checkOutput("model_255x3", expectedProduct(255, 3, 1'b0), 64'd756);
        checkOutput("model_ffff_sq", expectedProduct(16'hFFFF, 16'hFFFF, 1'b0), 64'd4161798144);

        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("por_res_valid", 64'(res_valid), 64'd0);
        checkOutput("por_res_data", 64'(res_data), 64'd0);
        checkOutput("por_req_ready", 64'(req_ready), 64'd0);
        rst_n     = 1'b1;
        req_valid = '0;

        applyStimulus(4'b0001, '0, 1'b0);
        setOperand(0, 3, 4);
        applyStimulus(4'b0001, '0, 1'b0);
        setOperand(0, 9, 11);
        @(posedge clk);
        #1;
        checkOutput("full_busy", 64'(busy), 64'd1);
        checkOutput("full_res_valid", 64'(res_valid), 64'd1);
        doReset();

        applyStimulus(4'b0001, '0, 1'b1);
        setOperand(0, 5, 7);
        #1;
        checkOutput("p5x7_ready", 64'(req_ready), 64'b0001);
        applyStimulus('0, '0, 1'b1);
        #1;
        checkOutput("p5x7_lat1_valid", 64'(res_valid), 64'd0);
        applyStimulus('0, '0, 1'b1);
        #1;
        checkOutput("p5x7_valid", 64'(res_valid), 64'd1);
        checkOutput("p5x7_data", 64'(res_data), 64'd35);
        checkOutput("p5x7_id", 64'(res_id), 64'd0);

        applyStimulus(4'b0100, 4'b0100, 1'b1);
        setOperand(2, 255, 3);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        #1;
        checkOutput("p255x3_data", 64'(res_data), BYPASS ? 64'd765 : 64'd756);
        checkOutput("p255x3_id", 64'(res_id), 64'd2);

        doReset();
        for (int c = 1; c <= 16; c++) begin
            applyStimulus(4'b1111, '0, 1'b1);
            randomOperands();
            #1;
            if (c >= 3) begin
                checkOutput("rr_valid", 64'(res_valid), 64'd1);
                checkOutput("rr_id", 64'(res_id), 64'((c - 3) % NREQ));
            end
        end
        repeat (3) applyStimulus('0, '0, 1'b1);

        a0 = acc_seen;
        r0 = res_seen;
        held = '0;
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(4'b0010, '0, 1'b0);
            randomOperands();
            #1;
            if (c == 3) held = res_data;
            if (c > 3) checkOutput("bp_hold_data", 64'(res_data), 64'(held));
        end
        checkOutput("bp_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("bp_accepts", 64'(acc_seen - a0), 64'd2);
        repeat (4) applyStimulus('0, '0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("bp_results", 64'(res_seen - r0), 64'd2);

        applyStimulus(4'b1000, '0, 1'b1);
        #1;
        checkOutput("fair_first3", 64'(req_ready), 64'b1000);
        applyStimulus(4'b1001, '0, 1'b1);
        #1;
        checkOutput("fair_then0", 64'(req_ready), 64'b0001);
        applyStimulus(4'b1001, '0, 1'b1);
        #1;
        checkOutput("fair_then3", 64'(req_ready), 64'b1000);
        repeat (3) applyStimulus('0, '0, 1'b1);

        a0 = acc_seen;
        r0 = res_seen;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(4'b0001, '0, (c % 2) == 0);
            randomOperands();
        end
        repeat (4) applyStimulus('0, '0, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("dr_count_match", 64'(res_seen - r0), 64'(acc_seen - a0));

        for (int c = 0; c < 400; c++) begin
            applyStimulus(NREQ'($urandom), NREQ'($urandom), $urandom_range(0, 9) < 7);
            randomOperands();
        end
        repeat (5) applyStimulus('0, '0, 1'b1);
        #1;
        checkOutput("final_empty", 64'(mq.size()), 64'd0);
        checkOutput("final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
